// File: rtl/kuznechik_pkg.sv
// Shared Kuznechik definitions: round/step counts, FSM states, L coefficients,
// fixed round keys, the Pi table with its inverse, and GF(2^8) multiplication.
package kuznechik_pkg;

  localparam int ROUNDS  = 10;
  localparam int L_STEPS = 16;

  typedef logic [127:0] block_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_KEY  = 3'd1,
    ST_LINV = 3'd2,
    ST_SINV = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Coefficients of the linear map l, applied to a15..a0 in that order.
  localparam logic [7:0] L_COEF [L_STEPS] = '{
    148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1
  };

  // Round keys K0..K9 for the reference key schedule.
  localparam block_t ROUND_KEYS [ROUNDS] = '{
    128'h8899aabbccddeeff0011223344556677,
    128'hfedcba98765432100123456789abcdef,
    128'hdb31485315694343228d6aef8cc78c44,
    128'h3d4553d8e9cfec6815ebadc40a9ffd04,
    128'h57646468c44a5e28d3e59246f429f1ac,
    128'hbd079435165c6432b532e82834da581b,
    128'h51e640757e8745de705727265a0098b1,
    128'h5a7925017b9fdd3ed72a91a22286f984,
    128'hbb44e25378c73123a5f32f73cdb6e517,
    128'h72e9dd7416bcf45b755dbaa88e4a4043
  };

  // Forward substitution Pi; the inverse table is derived from it.
  localparam logic [7:0] PI [256] = '{
    252, 238, 221,  17, 207, 110,  49,  22, 251, 196, 250, 218,  35, 197,   4,  77,
    233, 119, 240, 219, 147,  46, 153, 186,  23,  54, 241, 187,  20, 205,  95, 193,
    249,  24, 101,  90, 226,  92, 239,  33, 129,  28,  60,  66, 139,   1, 142,  79,
      5, 132,   2, 174, 227, 106, 143, 160,   6,  11, 237, 152, 127, 212, 211,  31,
    235,  52,  44,  81, 234, 200,  72, 171, 242,  42, 104, 162, 253,  58, 206, 204,
    181, 112,  14,  86,   8,  12, 118,  18, 191, 114,  19,  71, 156, 183,  93, 135,
     21, 161, 150,  41,  16, 123, 154, 199, 243, 145, 120, 111, 157, 158, 178, 177,
     50, 117,  25,  61, 255,  53, 138, 126, 109,  84, 198, 128, 195, 189,  13,  87,
    223, 245,  36, 169,  62, 168,  67, 201, 215, 121, 214, 246, 124,  34, 185,   3,
    224,  15, 236, 222, 122, 148, 176, 188, 220, 232,  40,  80,  78,  51,  10,  74,
    167, 151,  96, 115,  30,   0,  98,  68,  26, 184,  56, 130, 100, 159,  38,  65,
    173,  69,  70, 146,  39,  94,  85,  47, 140, 163, 165, 125, 105, 213, 149,  59,
      7,  88, 179,  64, 134, 172,  29, 247,  48,  55, 107, 228, 136, 217, 231, 137,
    225,  27, 131,  73,  76,  63, 248, 254, 141,  83, 170, 144, 202, 216, 133,  97,
     32, 113, 103, 164,  45,  43,   9,  91, 203, 155,  37, 208, 190, 229, 108,  82,
     89, 166, 116, 210, 230, 244, 180, 192, 209, 102, 175, 194,  57,  75,  99, 182
  };

  typedef logic [255:0][7:0] pi_tab_t;

  // Elaboration-time inversion of Pi, so only one table is maintained by hand.
  function automatic pi_tab_t build_pi_inv();
    pi_tab_t t;
    t = '0;
    for (int i = 0; i < 256; i++) t[PI[i]] = 8'(i);
    return t;
  endfunction

  localparam pi_tab_t PI_INV = build_pi_inv();

  // Multiplication in GF(2^8) modulo x^8 + x^7 + x^6 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'hc3) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

endpackage

// File: rtl/kuznechik_l_inv_step.sv
// One inverse-R step: shift the block left by a byte and append the
// linear combination of the rotated byte vector.
module kuznechik_l_inv_step
  import kuznechik_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);

  logic [7:0] x;

  // New low byte: coefficients walk b14..b0, then the old top byte b15 with weight 1.
  always_comb begin
    x = 8'h00;
    for (int j = 0; j < L_STEPS; j++) begin
      x = x ^ gf_mul(L_COEF[j], din[8 * ((30 - j) % 16) +: 8]);
    end
    dout = {din[119:0], x};
  end

endmodule

// File: rtl/kuznechik_decipher.sv
// Iterative Kuznechik block decryption: key XOR, 16 inverse-R steps and an
// inverse S layer per round, with a request/busy/valid/ack handshake.
//
// Handshake: request_i is looked at only in IDLE and starts a block on the
// edge it is seen high; busy_o is high from that edge until the result edge.
// valid_o rises with the result and data_o/valid_o stay frozen until ack_i is
// seen high in DONE; requests outside IDLE and acks outside DONE are dropped.
module kuznechik_decipher
  import kuznechik_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         request_i,
  input  logic         ack_i,
  input  logic [127:0] data_i,
  output logic         busy_o,
  output logic         valid_o,
  output logic [127:0] data_o,
  output logic [2:0]   dbg_state
);

  state_e     st;
  block_t     blk;
  logic [3:0] idx;
  logic [3:0] cnt;
  block_t     key_xor;
  block_t     linv_out;
  block_t     sinv_out;

  assign key_xor   = blk ^ ROUND_KEYS[idx];
  assign dbg_state = st;

  kuznechik_l_inv_step u_l_inv_step (
    .din  (blk),
    .dout (linv_out)
  );

  // Inverse S layer over all 16 bytes.
  always_comb begin
    sinv_out = '0;
    for (int i = 0; i < 16; i++) sinv_out[8 * i +: 8] = PI_INV[blk[8 * i +: 8]];
  end

  // Control FSM with registered outputs; round index counts down 9..0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st      <= ST_IDLE;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      data_o  <= '0;
      idx     <= 4'd9;
      cnt     <= 4'd0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (request_i) begin
            idx    <= 4'd9;
            busy_o <= 1'b1;
            st     <= ST_KEY;
          end
        end
        ST_KEY: begin
          if (idx == 4'd0) begin
            data_o  <= key_xor;
            valid_o <= 1'b1;
            busy_o  <= 1'b0;
            st      <= ST_DONE;
          end else begin
            st <= ST_LINV;
          end
        end
        ST_LINV: begin
          if (cnt == 4'(L_STEPS - 1)) begin
            cnt <= 4'd0;
            st  <= ST_SINV;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_SINV: begin
          idx <= idx - 4'd1;
          st  <= ST_KEY;
        end
        ST_DONE: begin
          if (ack_i) begin
            valid_o <= 1'b0;
            st      <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  // Working block; its contents are meaningless outside an active decryption.
  always_ff @(posedge clk_i) begin
    case (st)
      ST_IDLE: if (request_i) blk <= data_i;
      ST_KEY:  blk <= key_xor;
      ST_LINV: blk <= linv_out;
      ST_SINV: blk <= sinv_out;
      default: blk <= blk;
    endcase
  end

endmodule

// File: tb/tb_kuznechik_decipher.sv
// Bench for kuznechik_decipher: a forward-cipher reference model produces
// ciphertexts whose plaintexts are known, and each scenario checks timing,
// handshake behaviour and results.
module tb_kuznechik_decipher;
  import kuznechik_pkg::ST_IDLE;
  import kuznechik_pkg::ST_DONE;

  localparam int LAT = 163;
  localparam logic [127:0] GOST_CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
  localparam logic [127:0] GOST_PT = 128'h1122334455667700ffeeddccbbaa9988;

  localparam logic [7:0] TB_PI [256] = '{
    252, 238, 221,  17, 207, 110,  49,  22, 251, 196, 250, 218,  35, 197,   4,  77,
    233, 119, 240, 219, 147,  46, 153, 186,  23,  54, 241, 187,  20, 205,  95, 193,
    249,  24, 101,  90, 226,  92, 239,  33, 129,  28,  60,  66, 139,   1, 142,  79,
      5, 132,   2, 174, 227, 106, 143, 160,   6,  11, 237, 152, 127, 212, 211,  31,
    235,  52,  44,  81, 234, 200,  72, 171, 242,  42, 104, 162, 253,  58, 206, 204,
    181, 112,  14,  86,   8,  12, 118,  18, 191, 114,  19,  71, 156, 183,  93, 135,
     21, 161, 150,  41,  16, 123, 154, 199, 243, 145, 120, 111, 157, 158, 178, 177,
     50, 117,  25,  61, 255,  53, 138, 126, 109,  84, 198, 128, 195, 189,  13,  87,
    223, 245,  36, 169,  62, 168,  67, 201, 215, 121, 214, 246, 124,  34, 185,   3,
    224,  15, 236, 222, 122, 148, 176, 188, 220, 232,  40,  80,  78,  51,  10,  74,
    167, 151,  96, 115,  30,   0,  98,  68,  26, 184,  56, 130, 100, 159,  38,  65,
    173,  69,  70, 146,  39,  94,  85,  47, 140, 163, 165, 125, 105, 213, 149,  59,
      7,  88, 179,  64, 134, 172,  29, 247,  48,  55, 107, 228, 136, 217, 231, 137,
    225,  27, 131,  73,  76,  63, 248, 254, 141,  83, 170, 144, 202, 216, 133,  97,
     32, 113, 103, 164,  45,  43,   9,  91, 203, 155,  37, 208, 190, 229, 108,  82,
     89, 166, 116, 210, 230, 244, 180, 192, 209, 102, 175, 194,  57,  75,  99, 182
  };

  localparam logic [7:0] TB_COEF [16] = '{
    148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1
  };

  localparam logic [127:0] TB_KEYS [10] = '{
    128'h8899aabbccddeeff0011223344556677,
    128'hfedcba98765432100123456789abcdef,
    128'hdb31485315694343228d6aef8cc78c44,
    128'h3d4553d8e9cfec6815ebadc40a9ffd04,
    128'h57646468c44a5e28d3e59246f429f1ac,
    128'hbd079435165c6432b532e82834da581b,
    128'h51e640757e8745de705727265a0098b1,
    128'h5a7925017b9fdd3ed72a91a22286f984,
    128'hbb44e25378c73123a5f32f73cdb6e517,
    128'h72e9dd7416bcf45b755dbaa88e4a4043
  };

  logic         clk_i;
  logic         rst_i;
  logic         request_i;
  logic         ack_i;
  logic [127:0] data_i;
  logic         busy_o;
  logic         valid_o;
  logic [127:0] data_o;
  logic [2:0]   dbg_state;

  int           checks;
  int           errors;
  logic [127:0] last_pt;
  logic [127:0] exp_q [$];

  kuznechik_decipher dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .request_i (request_i),
    .ack_i     (ack_i),
    .data_i    (data_i),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .dbg_state (dbg_state)
  );

  // Clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- reference model: forward cipher ----------------
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h01c3 << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
    logic [127:0] a;
    logic [7:0]   x;
    a = pt;
    for (int r = 0; r < 9; r++) begin
      a = a ^ TB_KEYS[r];
      for (int i = 0; i < 16; i++) a[8 * i +: 8] = TB_PI[a[8 * i +: 8]];
      for (int s = 0; s < 16; s++) begin
        x = 8'h00;
        for (int j = 0; j < 16; j++) x = x ^ ref_mul(TB_COEF[j], a[8 * (15 - j) +: 8]);
        a = {x, a[127:8]};
      end
    end
    return a ^ TB_KEYS[9];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_i = 1'b1; request_i = 1'b0; ack_i = 1'b0; data_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    last_pt = '0;
  endtask

  task automatic start_req(input logic [127:0] ct, input string name);
    @(negedge clk_i);
    request_i = 1'b1;
    data_i    = ct;
    @(posedge clk_i);
    #1;
    request_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: busy_o=%b want 1", name, busy_o);
    end
  endtask

  // Waits the fixed latency after the accepting edge; optionally pokes
  // request_i/ack_i with junk data on cycles inj_a and inj_b.
  task automatic wait_result(input string name, input int inj_a, input int inj_b);
    logic [127:0] exp_pt;
    int           bad_k;
    exp_pt = exp_q.pop_front();
    bad_k  = 0;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk_i);
      #1;
      request_i = 1'b0;
      ack_i     = 1'b0;
      if (k < LAT) begin
        if (bad_k == 0 && (busy_o !== 1'b1 || valid_o !== 1'b0 || data_o !== last_pt)) bad_k = k;
        if (k == inj_a || k == inj_b) begin
          request_i = 1'b1;
          ack_i     = 1'b1;
          data_i    = rand128();
        end
      end
    end
    checks++;
    if (bad_k != 0) begin
      errors++;
      $display("FAIL %s in_flight: outputs wrong at cycle %0d (busy=%b valid=%b data_o=%h) want busy=1 valid=0 data_o=%h",
               name, bad_k, busy_o, valid_o, data_o, last_pt);
    end
    checks++;
    if (valid_o !== 1'b1 || busy_o !== 1'b0 || data_o !== exp_pt) begin
      errors++;
      $display("FAIL %s result: valid=%b busy=%b data_o=%h want valid=1 busy=0 data_o=%h",
               name, valid_o, busy_o, data_o, exp_pt);
    end
    last_pt = exp_pt;
  endtask

  task automatic do_ack(input string name);
    @(negedge clk_i);
    ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    ack_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || dbg_state !== ST_IDLE || data_o !== last_pt) begin
      errors++;
      $display("FAIL %s ack: valid=%b state=%0d data_o=%h want valid=0 state=%0d data_o=%h",
               name, valid_o, dbg_state, data_o, ST_IDLE, last_pt);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || data_o !== 128'h0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset: busy=%b valid=%b data_o=%h state=%0d want 0 0 0 %0d",
               busy_o, valid_o, data_o, dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_gost();
    exp_q.push_back(GOST_PT);
    start_req(GOST_CT, "gost");
    wait_result("gost", 0, 0);
    do_ack("gost");
  endtask

  task automatic test_hold_ack();
    logic [127:0] pt;
    int           bad_k;
    pt = rand128();
    exp_q.push_back(pt);
    start_req(ref_encrypt(pt), "hold");
    wait_result("hold", 0, 0);
    bad_k = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_i);
      #1;
      if (bad_k == 0 && (valid_o !== 1'b1 || busy_o !== 1'b0 || data_o !== pt || dbg_state !== ST_DONE))
        bad_k = k;
    end
    checks++;
    if (bad_k != 0) begin
      errors++;
      $display("FAIL hold: cycle %0d valid=%b busy=%b data_o=%h want valid=1 busy=0 data_o=%h",
               bad_k, valid_o, busy_o, data_o, pt);
    end
    do_ack("hold");
  endtask

  task automatic test_request_while_busy();
    logic [127:0] pt;
    pt = rand128();
    exp_q.push_back(pt);
    start_req(ref_encrypt(pt), "busy_req");
    wait_result("busy_req", 5, 100);
    do_ack("busy_req");
  endtask

  task automatic test_ack_with_request();
    logic [127:0] pt_a;
    logic [127:0] pt_b;
    pt_a = rand128();
    pt_b = rand128();
    exp_q.push_back(pt_a);
    start_req(ref_encrypt(pt_a), "ack_req_a");
    wait_result("ack_req_a", 0, 0);
    @(negedge clk_i);
    ack_i     = 1'b1;
    request_i = 1'b1;
    data_i    = ref_encrypt(pt_b);
    @(posedge clk_i);
    #1;
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL ack_req_same_cycle: busy=%b valid=%b state=%0d want 0 0 %0d",
               busy_o, valid_o, dbg_state, ST_IDLE);
    end
    @(negedge clk_i);
    ack_i = 1'b0;
    @(posedge clk_i);
    #1;
    request_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL ack_req_next_cycle: busy=%b want 1", busy_o);
    end
    exp_q.push_back(pt_b);
    wait_result("ack_req_b", 0, 0);
    do_ack("ack_req_b");
  endtask

  task automatic test_async_reset();
    exp_q.push_back(GOST_PT);
    start_req(GOST_CT, "areset");
    repeat (80) @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || data_o !== 128'h0) begin
      errors++;
      $display("FAIL async_reset: busy=%b valid=%b data_o=%h want 0 0 0", busy_o, valid_o, data_o);
    end
    void'(exp_q.pop_front());
    @(negedge clk_i);
    rst_i   = 1'b0;
    last_pt = '0;
    exp_q.push_back(GOST_PT);
    start_req(GOST_CT, "after_reset");
    wait_result("after_reset", 0, 0);
    do_ack("after_reset");
  endtask

  task automatic test_loopback(input int n);
    logic [127:0] pt;
    for (int i = 0; i < n; i++) begin
      pt = rand128();
      exp_q.push_back(pt);
      start_req(ref_encrypt(pt), "loopback");
      wait_result("loopback", 0, 0);
      do_ack("loopback");
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    do_reset();
    test_reset();
    test_gost();
    test_hold_ack();
    test_request_while_busy();
    test_ack_with_request();
    test_async_reset();
    test_loopback(60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
